// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave terminating one port onto a bank of byte-writable registers.
// AW and W buffer independently; errors flag read-only or unmapped targets.
module axi_lite_regfile_slave #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [1:0]                     rresp,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NREGS = ADDR_WIDTH'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic                           rdy_en_q, rdy_en_d;
    logic                           aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]          aw_addr_q, aw_addr_d;
    logic                           w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
    logic [STRB_W-1:0]              w_strb_q, w_strb_d;
    logic                           bvalid_q, bvalid_d;
    logic [1:0]                     bresp_q, bresp_d;
    logic                           rvalid_q, rvalid_d;
    logic [1:0]                     rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_word, rd_word;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_hit, rd_hit;
    logic                  unused_prot;

    assign unused_prot = ^{awprot, arprot};

    assign awready = rdy_en_q & ~aw_full_q & ~bvalid_q;
    assign wready  = rdy_en_q & ~w_full_q & ~bvalid_q;
    assign arready = rdy_en_q & ~rvalid_q;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    // A beat arriving this cycle counts as buffered, so commit can share its edge.
    assign commit = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~bvalid_q;

    assign wr_addr = aw_full_q ? aw_addr_q : awaddr;
    assign wr_data = w_full_q ? w_data_q : wdata;
    assign wr_strb = w_full_q ? w_strb_q : wstrb;

    assign wr_word = wr_addr >> LSB;
    assign wr_hit  = wr_word < NREGS;
    assign wr_idx  = wr_word[IDX_W-1:0];
    assign rd_word = araddr >> LSB;
    assign rd_hit  = rd_word < NREGS;
    assign rd_idx  = rd_word[IDX_W-1:0];

    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (!wr_hit) begin
                bresp_d = RESP_DECERR;
            end else if (RO_MASK[wr_idx]) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[int'(wr_idx)*DATA_WIDTH + b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample the pre-edge register image, so a same-edge write is not seen.
    always_comb begin
        rdy_en_d = 1'b1;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (rd_hit) begin
                rdata_d = regs_q[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_DECERR;
            end
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_en_q  <= 1'b0;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            regs_q    <= '0;
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign reg_out = regs_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Bench for axi_lite_regfile_slave: directed scenarios then random traffic
// against an array model of the register bank (16 x 32, reg3 read-only).
module tb_axi_lite_regfile_slave;

    logic         clk;
    logic         resetn;
    logic         awvalid, awready;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         wvalid, wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic         arvalid, arready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         rvalid, rready;
    logic [1:0]   rresp;
    logic [31:0]  rdata;
    logic [511:0] reg_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mdl [16];

    axi_lite_regfile_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .NUM_REGS  (16),
        .RO_MASK   (16'h0008)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .awprot (awprot),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .bvalid (bvalid),
        .bready (bready),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .arprot (arprot),
        .rvalid (rvalid),
        .rready (rready),
        .rresp  (rresp),
        .rdata  (rdata),
        .reg_out(reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] r);
        int unsigned idx;
        idx = a >> 2;
        if (idx >= 16) begin
            r = 2'b11;
        end else if (idx == 3) begin
            r = 2'b10;
        end else begin
            r = 2'b00;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d,
                              output logic [1:0] r);
        int unsigned idx;
        idx = a >> 2;
        if (idx >= 16) begin
            d = 32'h0;
            r = 2'b11;
        end else begin
            d = mdl[idx];
            r = 2'b00;
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = mdl[i];
        return f;
    endfunction

    // Presents AW and W after their own delays; returns at the negedge after
    // the later handshake, where the response must already be valid.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly,
                             input int w_dly, output logic [1:0] r);
        bit awd = 0;
        bit wd  = 0;
        bit ha, hw;
        int cyc = 0;
        @(negedge clk);
        while (!(awd && wd) && cyc < 100) begin
            awvalid = !awd && (cyc >= aw_dly);
            awaddr  = a;
            wvalid  = !wd && (cyc >= w_dly);
            wdata   = d;
            wstrb   = s;
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(posedge clk);
            @(negedge clk);
            awd = awd | ha;
            wd  = wd | hw;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_handshake", 512'(awd && wd), 512'(1));
        chk("wr_latency", 512'(bvalid), 512'(1));
        r = bresp;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        bit done = 0;
        bit hs;
        int cyc = 0;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = a;
        while (!done && cyc < 100) begin
            hs = arready;
            @(posedge clk);
            @(negedge clk);
            done = hs;
            cyc++;
        end
        arvalid = 1'b0;
        chk("rd_handshake", 512'(done), 512'(1));
        chk("rd_latency", 512'(rvalid), 512'(1));
        d = rdata;
        r = rresp;
    endtask

    initial begin
        logic [1:0]  r, er;
        logic [31:0] d, ed, a;
        logic [3:0]  s;

        resetn  = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b1;
        arvalid = 1'b0;
        araddr  = '0;
        arprot  = '0;
        rready  = 1'b1;
        model_clear();

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_readies", 512'({awready, wready, arready}), 512'(0));
        chk("rst_valids", 512'({bvalid, rvalid}), 512'(0));
        chk("rst_resps", 512'({bresp, rresp}), 512'(0));
        chk("rst_rdata", 512'(rdata), 512'(0));
        chk("rst_regs", reg_out, 512'(0));
        resetn = 1'b1;
        #1;
        chk("rel_first_edge_readies", 512'({awready, wready, arready}), 512'(0));
        @(posedge clk);
        @(negedge clk);
        chk("rel_second_edge_readies", 512'({awready, wready, arready}), 512'(7));

        // reset while a write response is pending
        bready = 1'b0;
        axi_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, r);
        chk("midwr_resp", 512'(r), 512'(0));
        chk("midwr_reg5", 512'(reg_out[191:160]), 512'(32'hCAFEF00D));
        resetn = 1'b0;
        #1;
        chk("midwr_rst_bvalid", 512'(bvalid), 512'(0));
        chk("midwr_rst_regs", reg_out, 512'(0));
        chk("midwr_rst_readies", 512'({awready, wready, arready}), 512'(0));
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midwr_rel_readies", 512'({awready, wready, arready}), 512'(7));
        chk("midwr_rel_bvalid", 512'(bvalid), 512'(0));
        chk("midwr_rel_regs", reg_out, 512'(0));

        // W three cycles ahead of AW
        axi_write(32'h8, 32'hDEADBEEF, 4'hF, 3, 0, r);
        model_write(32'h8, 32'hDEADBEEF, 4'hF, er);
        chk("wfirst_bresp", 512'(r), 512'(0));
        chk("wfirst_reg2", 512'(reg_out[95:64]), 512'(32'hDEADBEEF));
        axi_read(32'h8, d, r);
        chk("wfirst_rdata", 512'(d), 512'(32'hDEADBEEF));
        chk("wfirst_rresp", 512'(r), 512'(0));

        // partial strobe
        axi_write(32'h8, 32'h11223344, 4'b0101, 0, 0, r);
        model_write(32'h8, 32'h11223344, 4'b0101, er);
        chk("strb_bresp", 512'(r), 512'(0));
        chk("strb_reg2", 512'(reg_out[95:64]), 512'(32'hDE22BE44));

        // read-only and unmapped targets
        axi_write(32'hC, 32'h55AA55AA, 4'hF, 0, 1, r);
        model_write(32'hC, 32'h55AA55AA, 4'hF, er);
        chk("ro_bresp", 512'(r), 512'(2'b10));
        chk("ro_reg3", 512'(reg_out[127:96]), 512'(0));
        axi_write(32'h40, 32'h12345678, 4'hF, 1, 0, r);
        model_write(32'h40, 32'h12345678, 4'hF, er);
        chk("oor_bresp", 512'(r), 512'(2'b11));
        chk("oor_regs", reg_out, model_flat());
        axi_read(32'h40, d, r);
        chk("oor_rdata", 512'(d), 512'(0));
        chk("oor_rresp", 512'(r), 512'(2'b11));

        // response backpressure with a second write waiting
        bready = 1'b0;
        axi_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, r);
        model_write(32'h10, 32'hA5A5A5A5, 4'hF, er);
        chk("bp_first_bresp", 512'(r), 512'(0));
        awvalid = 1'b1;
        awaddr  = 32'h18;
        wvalid  = 1'b1;
        wdata   = 32'h0BADCAFE;
        wstrb   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_readies_low", 512'({awready, wready}), 512'(0));
            chk("bp_bvalid_held", 512'({bvalid, bresp}), 512'(3'b100));
        end
        chk("bp_reg6_untouched", 512'(reg_out[223:192]), 512'(0));
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_b_done", 512'(bvalid), 512'(0));
        chk("bp_readies_back", 512'({awready, wready}), 512'(3));
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        model_write(32'h18, 32'h0BADCAFE, 4'hF, er);
        chk("bp_second_bvalid", 512'(bvalid), 512'(1));
        chk("bp_second_bresp", 512'(bresp), 512'(0));
        chk("bp_second_regs", reg_out, model_flat());

        // write and read of reg1 on the same edge
        axi_write(32'h4, 32'h5, 4'hF, 0, 0, r);
        model_write(32'h4, 32'h5, 4'hF, er);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b1;
        awaddr  = 32'h4;
        wvalid  = 1'b1;
        wdata   = 32'h9;
        wstrb   = 4'hF;
        arvalid = 1'b1;
        araddr  = 32'h4;
        chk("coll_readies", 512'({awready, wready, arready}), 512'(7));
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        chk("coll_valids", 512'({bvalid, rvalid}), 512'(3));
        chk("coll_rdata_old", 512'(rdata), 512'(5));
        chk("coll_reg1_new", 512'(reg_out[63:32]), 512'(9));
        model_write(32'h4, 32'h9, 4'hF, er);
        axi_read(32'h4, d, r);
        chk("coll_reread", 512'(d), 512'(9));

        // random traffic against the model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 'h4F));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
                model_write(a, d, s, er);
                chk("rnd_bresp", 512'(r), 512'(er));
                chk("rnd_regs", reg_out, model_flat());
            end else begin
                model_read(a, ed, er);
                axi_read(a, d, r);
                chk("rnd_rdata", 512'(d), 512'(ed));
                chk("rnd_rresp", 512'(r), 512'(er));
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
